burst_sender: RTL and testbench

BURST_SENDER -- requirements
Module: burst_sender

---
 rtl/burst_sender_pkg.sv | 55 +++++
 rtl/burst_sender_pattern_gen.sv | 19 +
 rtl/burst_sender.sv | 111 +++++++++++
 tb/tb_burst_sender.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/burst_sender_pkg.sv
// Shared types and pattern arithmetic for the burst sender.
// Word helpers work on a wide container so any DATA_W up to MAX_W can reuse them.
package burst_sender_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        MODE_INCR  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_WALK1 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned width);
        if (width >= MAX_W)
            width_mask = '1;
        else
            width_mask = (MAX_W'(1) << width) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] next_word(
        input mode_e             mode,
        input logic [MAX_W-1:0]  word,
        input logic [MAX_W-1:0]  taps,
        input int unsigned       width
    );
        logic [MAX_W-1:0] mask;
        mask = width_mask(width);
        case (mode)
            MODE_INCR:  next_word = (word + 1'b1) & mask;
            MODE_CONST: next_word = word;
            MODE_LFSR:  next_word = (word >> 1) ^ (word[0] ? taps : '0);
            // Rotate left within the active width, MSB wrapping into bit 0.
            default:    next_word = ((word << 1) | (word >> (width - 1))) & mask;
        endcase
    endfunction

    function automatic logic [MAX_W-1:0] first_word(
        input mode_e             mode,
        input logic [MAX_W-1:0]  seed
    );
        case (mode)
            MODE_LFSR:  first_word = (seed == '0) ? MAX_W'(1) : seed;
            MODE_WALK1: first_word = MAX_W'(1);
            default:    first_word = seed;
        endcase
    endfunction

endpackage

// File: rtl/burst_sender_pattern_gen.sv
// Combinational pattern unit: first word of a burst and successor of the current word.
module pattern_gen
    import burst_sender_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  mode_e             start_mode,
    input  logic [DATA_W-1:0] seed,
    input  mode_e             run_mode,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] first_data,
    output logic [DATA_W-1:0] next_data
);

    assign first_data = DATA_W'(first_word(start_mode, MAX_W'(seed)));
    assign next_data  = DATA_W'(next_word(run_mode, MAX_W'(word), MAX_W'(LFSR_TAPS), DATA_W));

endmodule

// File: rtl/burst_sender.sv
// Burst sender: on trigger, writes burst_len pattern words into a downstream FIFO,
// honouring fifo_full backpressure and an abort request.
module burst_sender
    import burst_sender_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                LEN_W     = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic              pll99_outclk_0,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              abort,
    input  logic              fifo_full,
    output logic              fifo_req,
    output logic [DATA_W-1:0] fifo_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  sent_cnt
);

    state_e            state_reg;
    mode_e             mode_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic [LEN_W-1:0]  cnt_next;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] first_data;
    logic [DATA_W-1:0] next_data;
    logic              busy_reg;
    logic              done_reg;

    pattern_gen #(
        .DATA_W    (DATA_W),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_pattern_gen (
        .start_mode (mode_e'(mode)),
        .seed       (seed),
        .run_mode   (mode_reg),
        .word       (data_reg),
        .first_data (first_data),
        .next_data  (next_data)
    );

    // The write strobe must react to fifo_full/abort within the same cycle.
    assign fifo_req = (state_reg == ST_SEND) && !fifo_full && !abort;
    assign cnt_next = cnt_reg + 1'b1;

    always_ff @(posedge pll99_outclk_0 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            mode_reg  <= MODE_INCR;
            len_reg   <= '0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (trigger) begin
                        mode_reg <= mode_e'(mode);
                        len_reg  <= burst_len;
                        cnt_reg  <= '0;
                        data_reg <= first_data;
                        busy_reg <= 1'b1;
                        if (burst_len != '0) begin
                            state_reg <= ST_SEND;
                        end else begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else if (!fifo_full) begin
                        cnt_reg  <= cnt_next;
                        data_reg <= next_data;
                        if (cnt_next == len_reg) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_data = data_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign sent_cnt  = cnt_reg;

endmodule

// File: tb/tb_burst_sender.sv
module tb_burst_sender;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trigger;
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] burst_len;
    logic       abort;
    logic       fifo_full;
    logic       fifo_req;
    logic [7:0] fifo_data;
    logic       busy;
    logic       done;
    logic [7:0] sent_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    burst_sender dut (
        .pll99_outclk_0 (clk),
        .rst_n          (rst_n),
        .trigger        (trigger),
        .mode           (mode),
        .seed           (seed),
        .burst_len      (burst_len),
        .abort          (abort),
        .fifo_full      (fifo_full),
        .fifo_req       (fifo_req),
        .fifo_data      (fifo_data),
        .busy           (busy),
        .done           (done),
        .sent_cnt       (sent_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_word(input logic [1:0] m, input logic [7:0] s, input int i);
        logic [7:0] w;
        case (m)
            2'd0: ref_word = s + 8'(i);
            2'd1: ref_word = s;
            2'd2: begin
                w = (s == 8'd0) ? 8'd1 : s;
                for (int j = 0; j < i; j++)
                    w = w[0] ? ((w >> 1) ^ 8'hB8) : (w >> 1);
                ref_word = w;
            end
            default: ref_word = 8'(1 << (i % 8));
        endcase
    endfunction

    task automatic run_burst(input logic [1:0] m, input logic [7:0] s, input logic [7:0] len,
                             input logic [63:0] stall, input int abort_at,
                             input bit trig_during, input string tag);
        logic [7:0] obs_q[$];
        int n_exp;
        int done_exp;
        int done_obs;
        logic full_k;

        n_exp = 0;
        done_exp = 0;
        if (len != 8'd0) begin
            for (int k = 0; k < 200; k++) begin
                full_k = (k < 64) ? stall[k] : 1'b0;
                if (k == abort_at) begin
                    done_exp = k + 1;
                    break;
                end
                if (!full_k) begin
                    n_exp++;
                    if (n_exp == int'(len)) begin
                        done_exp = k + 1;
                        break;
                    end
                end
            end
        end

        @(posedge clk); #1;
        trigger = 1'b1; mode = m; seed = s; burst_len = len;
        fifo_full = 1'b0; abort = 1'b0;
        @(negedge clk);
        check($sformatf("%s idle_busy", tag), busy, 1'b0);

        done_obs = -1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            trigger   = trig_during;
            mode      = 2'($urandom);
            seed      = 8'($urandom);
            burst_len = 8'($urandom);
            fifo_full = (k < 64) ? stall[k] : 1'b0;
            abort     = (k == abort_at);
            @(negedge clk);
            check($sformatf("%s busy_c%0d", tag, k), busy, 1'b1);
            if (fifo_full || abort)
                check($sformatf("%s req_blocked_c%0d", tag, k), fifo_req, 1'b0);
            if (fifo_req === 1'b1)
                obs_q.push_back(fifo_data);
            if (done === 1'b1) begin
                done_obs = k;
                check($sformatf("%s sent_cnt_at_done", tag), sent_cnt, 8'(n_exp));
                break;
            end
        end

        check($sformatf("%s done_cycle", tag), done_obs, done_exp);
        check($sformatf("%s word_count", tag), obs_q.size(), n_exp);
        for (int i = 0; i < obs_q.size() && i < n_exp; i++)
            check($sformatf("%s word%0d", tag, i), obs_q[i], ref_word(m, s, i));

        @(posedge clk); #1;
        trigger = 1'b0; fifo_full = 1'b0; abort = 1'b0;
        @(negedge clk);
        check($sformatf("%s done_one_cycle", tag), done, 1'b0);
        check($sformatf("%s busy_after", tag), busy, 1'b0);
        check($sformatf("%s sent_cnt_hold", tag), sent_cnt, 8'(n_exp));
        check($sformatf("%s req_idle", tag), fifo_req, 1'b0);

        $display("[TB] burst %s mode=%0d seed=%02h len=%0d words=%0d done_at=%0d",
                 tag, m, s, len, obs_q.size(), done_obs);
    endtask

    initial begin
        logic [1:0]  rm;
        logic [7:0]  rs;
        logic [7:0]  rl;
        logic [63:0] rstall;
        int          rab;

        rst_n = 1'b0; trigger = 1'b0; mode = 2'd0; seed = 8'd0;
        burst_len = 8'd0; abort = 1'b0; fifo_full = 1'b0;
        #2;
        check("reset fifo_req", fifo_req, 1'b0);
        check("reset fifo_data", fifo_data, 8'h00);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset sent_cnt", sent_cnt, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_burst(2'd0, 8'hFE, 8'd4, 64'd0, -1, 1'b0, "incr_wrap");
        run_burst(2'd1, 8'h5A, 8'd3, 64'b1110, -1, 1'b0, "const_stall");
        run_burst(2'd2, 8'h00, 8'd3, 64'd0, -1, 1'b0, "lfsr_seed0");
        run_burst(2'd3, 8'h77, 8'd8, 64'd0, 2, 1'b1, "walk1_abort");
        run_burst(2'd3, 8'h00, 8'd10, 64'd0, -1, 1'b0, "walk1_wrap");
        run_burst(2'd0, 8'h33, 8'd0, 64'd0, -1, 1'b0, "zero_len");
        run_burst(2'd2, 8'h01, 8'd5, 64'hFF, 3, 1'b0, "abort_while_full");

        @(posedge clk); #1;
        trigger = 1'b1; mode = 2'd0; seed = 8'h10; burst_len = 8'd10;
        @(posedge clk); #1;
        trigger = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst fifo_req", fifo_req, 1'b0);
        check("midrst fifo_data", fifo_data, 8'h00);
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst sent_cnt", sent_cnt, 8'h00);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("midrst no_done_c%0d", c), done, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("[TB] reset mid-burst applied and released");
        run_burst(2'd0, 8'h10, 8'd5, 64'd0, -1, 1'b0, "after_reset");

        for (int t = 0; t < 30; t++) begin
            rm     = 2'($urandom_range(0, 3));
            rs     = 8'($urandom);
            rl     = 8'($urandom_range(0, 20));
            rstall = {$urandom, $urandom} & {$urandom, $urandom};
            rab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : -1;
            run_burst(rm, rs, rl, rstall, rab, 1'($urandom_range(0, 1)),
                      $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
